booth_mult_arbiter: RTL and testbench

BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

---
 rtl/booth_mult_arbiter.sv | 126 ++++++++++++
 tb/tb_booth_mult_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - two-requester round-robin front end for a shared signed multiplier
module booth_mult_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [1:0]     req_valid,
    input  logic [N-1:0]   req_multiplicand0,
    input  logic [N-1:0]   req_multiplicand1,
    input  logic [N-1:0]   req_multiplier0,
    input  logic [N-1:0]   req_multiplier1,
    output logic [1:0]     req_ready,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [2*N-1:0] resp_product,
    output logic           resp_err,
    output logic           mul_start,
    output logic [N-1:0]   mul_multiplicand,
    output logic [N-1:0]   mul_multiplier,
    input  logic [2*N-1:0] mul_product,
    input  logic           mul_done,
    output logic           busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic             owner_q;
    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     mcand_q;
    logic [N-1:0]     mplier_q;
    logic [2*N-1:0]   prod_q;
    logic             err_q;
    logic             start_q;
    logic             busy_q;
    logic [1:0]       resp_valid_q;

    logic             grant_idx;
    logic             grant_en;

    // A lone requester always wins; prio only breaks a tie.
    assign grant_idx = (req_valid == 2'b11) ? prio_q : req_valid[1];
    assign grant_en  = reset_n && (state_q == S_IDLE) && (req_valid != 2'b00);
    assign req_ready = grant_en ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            prod_q       <= '0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 2'b00;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        owner_q  <= grant_idx;
                        mcand_q  <= grant_idx ? req_multiplicand1 : req_multiplicand0;
                        mplier_q <= grant_idx ? req_multiplier1 : req_multiplier0;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (mul_done) begin
                        prod_q       <= mul_product;
                        err_q        <= 1'b0;
                        mcand_q      <= '0;
                        mplier_q     <= '0;
                        resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        prod_q       <= '0;
                        err_q        <= 1'b1;
                        mcand_q      <= '0;
                        mplier_q     <= '0;
                        resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        busy_q       <= 1'b0;
                        prio_q       <= ~owner_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_product     = prod_q;
    assign resp_err         = err_q;
    assign mul_start        = start_q;
    assign mul_multiplicand = mcand_q;
    assign mul_multiplier   = mplier_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - scoreboard bench for booth_mult_arbiter with a behavioural multiplier
module tb_booth_mult_arbiter;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           rv0, rv1;
    logic [N-1:0]   a0, b0, a1, b1;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_rdy;
    logic [2*N-1:0] resp_product;
    logic           resp_err;
    logic           mul_start;
    logic [N-1:0]   mul_mc, mul_mr;
    logic [2*N-1:0] mul_product;
    logic           mdl_done, spur_done, mul_done;
    logic           busy;
    logic           mul_en;
    int             mul_lat;

    typedef struct {
        int             idx;
        logic [2*N-1:0] prod;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   resp_start_cyc = 0;
    logic [1:0] prev_rv = 2'b00;
    logic signed [2*N-1:0] ma, mb;

    assign req_valid = {rv1, rv0};
    assign mul_done  = mdl_done | spur_done;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    booth_mult_arbiter #(.N(N), .TIMEOUT(64)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid),
        .req_multiplicand0(a0), .req_multiplicand1(a1),
        .req_multiplier0(b0), .req_multiplier1(b1),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_rdy),
        .resp_product(resp_product), .resp_err(resp_err), .mul_start(mul_start),
        .mul_multiplicand(mul_mc), .mul_multiplier(mul_mr),
        .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural multiplier: done arrives mul_lat cycles after the start pulse.
    initial begin
        mdl_done = 1'b0;
        mul_product = '0;
        forever begin
            @(posedge clock); #1;
            if (mul_start && mul_en) begin
                ma = {{N{mul_mc[N-1]}}, mul_mc};
                mb = {{N{mul_mr[N-1]}}, mul_mr};
                repeat (mul_lat) begin @(posedge clock); #1; end
                mdl_done = 1'b1;
                mul_product = ma * mb;
                @(posedge clock); #1;
                mdl_done = 1'b0;
                mul_product = '0;
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each response handshake.
    initial begin
        forever begin
            @(negedge clock);
            chk("req_ready_excl", 32'((req_ready == 2'b11) || (busy && req_ready != 2'b00)), 0);
            if (resp_valid != 2'b00 && prev_rv == 2'b00) resp_start_cyc = cyc;
            prev_rv = resp_valid;
            if ((resp_valid & resp_rdy) != 2'b00) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=%b expected no response", resp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", 32'(resp_valid), (e.idx != 0) ? 2'b10 : 2'b01);
                    chk("resp_product", 32'(resp_product), 32'(e.prod));
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic issue(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp_p, input logic exp_e);
        bit got = 1'b0;
        @(posedge clock); #1;
        if (idx == 0) begin a0 = a; b0 = b; rv0 = 1'b1; end
        else begin a1 = a; b1 = b; rv1 = 1'b1; end
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (req_ready[idx]) begin
                got = 1'b1;
                acc_cyc = cyc;
                sb.push_back(exp_t'{idx, exp_p, exp_e});
                grants.push_back(idx);
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: requester %0d got no req_ready, expected a grant", idx);
        end
        @(posedge clock); #1;
        if (idx == 0) rv0 = 1'b0; else rv1 = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: %0d responses outstanding, busy=%b, expected 0", sb.size(), busy);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        reset_n = 1'b1;
    endtask

    initial begin
        automatic int exp_sim[4] = '{0, 1, 0, 1};
        automatic int exp_rr[3]  = '{0, 1, 0};
        automatic bit seen = 1'b0;
        reset_n = 1'b0; rv0 = 1'b1; rv1 = 1'b1;
        a0 = 4'h5; b0 = 4'h5; a1 = 4'h3; b1 = 4'h3;
        resp_rdy = 2'b11; mul_en = 1'b1; mul_lat = 1; spur_done = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_resp_valid", 32'(resp_valid), 0);
        chk("reset_mul_start", 32'(mul_start), 0);
        chk("reset_operands", 32'({mul_mc, mul_mr}), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_product", 32'({resp_err, resp_product}), 0);
        @(posedge clock); #1;
        rv0 = 1'b0; rv1 = 1'b0;
        reset_n = 1'b1;

        issue(0, 4'd3, 4'hE, 8'hFA, 1'b0);
        wait_done();
        chk("latency_single", 32'(resp_start_cyc - acc_cyc), 3);

        pulse_reset();
        grants.delete();
        repeat (2) begin
            fork
                issue(0, 4'd5, 4'd5, 8'h19, 1'b0);
                issue(1, 4'h8, 4'h8, 8'h40, 1'b0);
            join
            wait_done();
        end
        chk("grants_sim_n", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order_sim", grants[i], exp_sim[i]);

        grants.delete();
        mul_lat = 3;
        fork
            begin
                issue(0, 4'd2, 4'd3, 8'h06, 1'b0);
                issue(0, 4'hF, 4'd7, 8'hF9, 1'b0);
            end
            begin
                for (int i = 0; i < 400 && grants.size() == 0; i++) @(negedge clock);
                issue(1, 4'h9, 4'd2, 8'hF2, 1'b0);
            end
        join
        wait_done();
        chk("grants_rr_n", grants.size(), 3);
        for (int i = 0; i < 3 && i < grants.size(); i++) chk("grant_order_rr", grants[i], exp_rr[i]);

        resp_rdy = 2'b01;
        mul_lat = 2;
        issue(1, 4'd7, 4'd7, 8'h31, 1'b0);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (resp_valid[1]) seen = 1'b1;
        end
        chk("bp_resp_seen", 32'(seen), 1);
        @(posedge clock); #1;
        a0 = 4'd1; b0 = 4'd1; rv0 = 1'b1;
        repeat (10) begin
            @(negedge clock);
            chk("bp_resp_valid", 32'(resp_valid), 2'b10);
            chk("bp_product", 32'(resp_product), 8'h31);
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        @(posedge clock); #1;
        rv0 = 1'b0;
        resp_rdy = 2'b11;
        @(negedge clock);
        @(negedge clock);
        chk("bp_release_busy", 32'(busy), 0);
        wait_done();

        mul_en = 1'b0;
        mul_lat = 1;
        issue(0, 4'd3, 4'd3, 8'h00, 1'b1);
        wait_done();
        chk("latency_timeout", 32'(resp_start_cyc - acc_cyc), 66);

        issue(1, 4'd2, 4'd2, 8'h04, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        chk("wait_busy", 32'(busy), 1);
        void'(sb.pop_back());
        pulse_reset();
        spur_done = 1'b1;
        @(posedge clock); #1;
        spur_done = 1'b0;
        mul_en = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("post_rst_resp_valid", 32'(resp_valid), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        grants.delete();
        fork
            issue(0, 4'd1, 4'hF, 8'hFF, 1'b0);
            issue(1, 4'd6, 4'd2, 8'h0C, 1'b0);
        join
        wait_done();
        chk("post_rst_prio", (grants.size() > 0) ? grants[0] : -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 300000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
